// File: rtl/mario_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mario_pkg
// Description : Shared types and constants for the player motion integrator:
//               motion state enum, USB HID key codes, 12-bit signed velocity
//               type and a saturating clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mario_pkg;

    // Player vertical motion state
    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } mario_state_t;

    // USB HID usage codes for the keys we react to
    localparam logic [7:0] c_key_left  = 8'h04;  // A
    localparam logic [7:0] c_key_right = 8'h07;  // D
    localparam logic [7:0] c_key_jump  = 8'h1A;  // W
    localparam logic [7:0] c_key_space = 8'h2C;  // space

    // All position/velocity arithmetic is done in this width so that sums
    // of a 10-bit position and two velocity terms can never wrap.
    typedef logic signed [11:0] vel_t;

    // Saturate v into [lo, hi]
    function automatic vel_t clamp_vel(input vel_t v, input vel_t lo, input vel_t hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mario_key_decode.sv
`default_nettype none
// ============================================================================
// Module      : mario_key_decode
// Description : Combinational scan of the four packed HID key bytes. Reports
//               whether left, right or jump is held in any slot. No edge
//               detection here; the parent owns that history.
// Revision    : 1.0 - initial release
// ============================================================================
module mario_key_decode
    import mario_pkg::*;
(
    input  logic [31:0] i_keycode,
    output logic        o_left,
    output logic        o_right,
    output logic        o_jump
);

    // Any-slot match for each key of interest
    always_comb begin
        o_left  = 1'b0;
        o_right = 1'b0;
        o_jump  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i_keycode[8*i +: 8] == c_key_left) begin
                o_left = 1'b1;
            end
            if (i_keycode[8*i +: 8] == c_key_right) begin
                o_right = 1'b1;
            end
            if ((i_keycode[8*i +: 8] == c_key_jump) ||
                (i_keycode[8*i +: 8] == c_key_space)) begin
                o_jump = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mario_physics.sv
`default_nettype none
// ============================================================================
// Module      : mario_physics
// Description : Per-frame motion integrator for the player sprite. Decodes
//               keys, requests jumps from the jump FSM, integrates its
//               velocity profile during the rise, applies gravity during the
//               fall, walks and clamps horizontally, and pulses hit_ground
//               on landing.
// Config      : MARIO_AIR_CONTROL_EN - when defined, walking input is honoured
//               while airborne; otherwise the walk direction is latched at
//               takeoff and facing is frozen in the air.
// Revision    : 1.0 - initial release
// ============================================================================
module mario_physics
    import mario_pkg::*;
#(
    parameter int GROUND_Y    = 400,
    parameter int X_START     = 80,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 624,
    parameter int Y_MIN       = 0,
    parameter int WALK_STEP   = 2,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 8,
    parameter int JUMP_FRAMES = 20
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic [9:0]  jump_x_motion,
    input  logic [9:0]  jump_y_motion,
    output logic        jump_en,
    output logic        hit_ground,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        facing_left,
    output logic        airborne
);

    localparam vel_t       c_ground      = vel_t'(GROUND_Y);
    localparam vel_t       c_x_min       = vel_t'(X_MIN);
    localparam vel_t       c_x_max       = vel_t'(X_MAX);
    localparam vel_t       c_y_min       = vel_t'(Y_MIN);
    localparam vel_t       c_y_cap       = 12'sd1023;
    localparam vel_t       c_walk        = vel_t'(WALK_STEP);
    localparam vel_t       c_gravity     = vel_t'(GRAVITY);
    localparam vel_t       c_max_fall    = vel_t'(MAX_FALL);
    localparam logic [7:0] c_jump_frames = 8'(JUMP_FRAMES);

    logic         w_left, w_right, w_jump;
    logic         w_jump_edge;

    mario_state_t r_state, w_state_nxt;
    logic [7:0]   r_rise_cnt, w_rise_nxt;
    vel_t         r_fall_vel, w_fall_nxt;
    logic [9:0]   r_pos_x, w_pos_x_nxt;
    logic [9:0]   r_pos_y, w_pos_y_nxt;
    logic         r_jump_prev;
    logic         r_jump_en, w_jump_en_nxt;
    logic         r_hit_ground, w_hit_nxt;
    logic         r_facing_left, w_face_nxt;
    logic         r_airborne;
    logic         w_face_upd;

    vel_t         w_dx_key, w_dx_eff;
    vel_t         w_jx, w_jy, w_px, w_py;
    vel_t         w_x_sum, w_y_sum, w_fv_step;
`ifndef MARIO_AIR_CONTROL_EN
    vel_t         r_dx_latch, w_dx_latch_nxt;
`endif

    mario_key_decode u_key_decode (
        .i_keycode (keycode),
        .o_left    (w_left),
        .o_right   (w_right),
        .o_jump    (w_jump)
    );

    assign jump_en     = r_jump_en;
    assign hit_ground  = r_hit_ground;
    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign facing_left = r_facing_left;
    assign airborne    = r_airborne;

    // Next-state and next-output computation for one frame
    always_comb begin
        w_state_nxt   = r_state;
        w_rise_nxt    = r_rise_cnt;
        w_fall_nxt    = r_fall_vel;
        w_pos_y_nxt   = r_pos_y;
        w_jump_en_nxt = 1'b0;
        w_hit_nxt     = 1'b0;
        w_face_nxt    = r_facing_left;
        w_y_sum       = '0;
        w_fv_step     = '0;
`ifndef MARIO_AIR_CONTROL_EN
        w_dx_latch_nxt = r_dx_latch;
`endif

        w_jx = {{2{jump_x_motion[9]}}, jump_x_motion};
        w_jy = {{2{jump_y_motion[9]}}, jump_y_motion};
        w_px = {2'b00, r_pos_x};
        w_py = {2'b00, r_pos_y};

        w_jump_edge = w_jump && !r_jump_prev;

        // Opposing keys cancel and leave facing alone
        w_dx_key = '0;
        if (w_right && !w_left) begin
            w_dx_key = c_walk;
        end else if (w_left && !w_right) begin
            w_dx_key = -c_walk;
        end

`ifdef MARIO_AIR_CONTROL_EN
        w_dx_eff   = w_dx_key;
        w_face_upd = 1'b1;
`else
        w_dx_eff   = (r_state == GROUNDED) ? w_dx_key : r_dx_latch;
        w_face_upd = (r_state == GROUNDED);
`endif

        if (w_face_upd && w_right && !w_left) begin
            w_face_nxt = 1'b0;
        end else if (w_face_upd && w_left && !w_right) begin
            w_face_nxt = 1'b1;
        end

        w_x_sum     = w_px + w_dx_eff + w_jx;
        w_pos_x_nxt = 10'(clamp_vel(w_x_sum, c_x_min, c_x_max));

        case (r_state)
            GROUNDED: begin
                if (w_jump_edge) begin
                    w_jump_en_nxt = 1'b1;
                    w_rise_nxt    = '0;
                    w_fall_nxt    = '0;
                    w_state_nxt   = RISING;
`ifndef MARIO_AIR_CONTROL_EN
                    w_dx_latch_nxt = w_dx_key;
`endif
                end
            end
            RISING: begin
                w_y_sum    = w_py + w_jy;
                w_rise_nxt = r_rise_cnt + 8'd1;
                if (w_y_sum < c_y_min) begin
                    // Bumped the ceiling: start falling immediately
                    w_pos_y_nxt = 10'(c_y_min);
                    w_fall_nxt  = '0;
                    w_state_nxt = FALLING;
                end else begin
                    w_pos_y_nxt = 10'(clamp_vel(w_y_sum, c_y_min, c_y_cap));
                    if (w_rise_nxt == c_jump_frames) begin
                        w_fall_nxt  = '0;
                        w_state_nxt = FALLING;
                    end
                end
            end
            FALLING: begin
                w_fv_step = r_fall_vel + c_gravity;
                if (w_fv_step > c_max_fall) begin
                    w_fv_step = c_max_fall;
                end
                w_fall_nxt = w_fv_step;
                w_y_sum    = w_py + w_fv_step;
                if (w_y_sum >= c_ground) begin
                    w_pos_y_nxt = 10'(c_ground);
                    w_fall_nxt  = '0;
                    w_hit_nxt   = 1'b1;
                    w_state_nxt = GROUNDED;
                end else begin
                    w_pos_y_nxt = 10'(w_y_sum);
                end
            end
            default: begin
                w_state_nxt = GROUNDED;
            end
        endcase
    end

    // Frame-rate state and output registers
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state       <= GROUNDED;
            r_rise_cnt    <= '0;
            r_fall_vel    <= '0;
            r_pos_x       <= 10'(X_START);
            r_pos_y       <= 10'(GROUND_Y);
            r_jump_prev   <= 1'b0;
            r_jump_en     <= 1'b0;
            r_hit_ground  <= 1'b0;
            r_facing_left <= 1'b0;
            r_airborne    <= 1'b0;
`ifndef MARIO_AIR_CONTROL_EN
            r_dx_latch    <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_rise_cnt    <= w_rise_nxt;
            r_fall_vel    <= w_fall_nxt;
            r_pos_x       <= w_pos_x_nxt;
            r_pos_y       <= w_pos_y_nxt;
            r_jump_prev   <= w_jump;
            r_jump_en     <= w_jump_en_nxt;
            r_hit_ground  <= w_hit_nxt;
            r_facing_left <= w_face_nxt;
            r_airborne    <= (w_state_nxt != GROUNDED);
`ifndef MARIO_AIR_CONTROL_EN
            r_dx_latch    <= w_dx_latch_nxt;
`endif
        end
    end

endmodule
`default_nettype wire
